// File: rtl/tut_nios_pll_reset_ctrl.sv
// Reset sequencer around the system/SDRAM PLL: pulses PLL reset, qualifies lock, releases sys reset.
// Optional saturating lock-loss counter enabled by defining PLL_RST_LOCK_LOSS_CNT_EN.
module tut_nios_pll_reset_ctrl #(
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_TIMEOUT       = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned SYNC_STAGES        = 2
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       lock_fail,
    output logic [7:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStable,
        StRun,
        StFail
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [7:0]             retry_q, retry_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk;
    logic                   pll_rst_q, sys_reset_n_q, lock_fail_q;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lk = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        unique case (state_q)
            StResetPll: begin
                if (cnt_q == PLL_RST_CYCLES - 1) state_d = StWaitLock;
            end
            StWaitLock: begin
                // Lock takes priority over a timeout landing on the same cycle.
                if (lk) begin
                    state_d = StStable;
                end else if (cnt_q == LOCK_TIMEOUT - 1) begin
                    retry_d = (retry_q == 8'hff) ? retry_q : retry_q + 8'd1;
                    state_d = (32'(retry_d) >= MAX_RETRIES) ? StFail : StResetPll;
                end
            end
            StStable: begin
                if (!lk) begin
                    state_d = StWaitLock;
                end else if (cnt_q == LOCK_STABLE_CYCLES - 1) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!lk) state_d = StResetPll;
            end
            StFail: begin
                state_d = StFail;
            end
            default: begin
                state_d = StResetPll;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q inside {StResetPll, StWaitLock, StStable}) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StResetPll;
            cnt_q         <= '0;
            retry_q       <= '0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            lock_fail_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            pll_rst_q     <= (state_d == StResetPll);
            sys_reset_n_q <= (state_d == StRun);
            lock_fail_q   <= (state_d == StFail);
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_reset_n = sys_reset_n_q;
    assign lock_fail   = lock_fail_q;
    assign retry_cnt   = retry_q;

`ifdef PLL_RST_LOCK_LOSS_CNT_EN
    logic [7:0] loss_q;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if (state_q == StRun && !lk && loss_q != 8'hff) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule
